seq_restoring_divider: RTL

- Multi-cycle unsigned integer divider built around repeated trial subtraction. It runs one WIDTH-bit subtraction per clock and produces one quotient bit per cycle.
- Sits directly downstream of the team's 8-bit ripple subtractor datapath. It consumes that subtract/borrow result iteratively to build quotient and remainder.
- Start/done handshake to the controlling sequencer; outputs held stable until the next operation.

---
 rtl/seq_restoring_divider_pkg.sv | 8 +
 rtl/seq_restoring_divider_trial_sub.sv | 17 +
 rtl/seq_restoring_divider.sv | 87 ++++++++
 3 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// seq_restoring_divider_pkg: FSM state encoding, default width and counter sizing for the restoring divider
package seq_restoring_divider_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_DONE = 2'd2} state_t;
  localparam int DIV_WIDTH = 8;
  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction
endpackage

// File: rtl/seq_restoring_divider_trial_sub.sv
// div_trial_sub: ripple-borrow (WIDTH+1)-bit subtract a-b giving diff and borrow-out
module div_trial_sub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] a,
  input  logic [WIDTH:0] b,
  output logic [WIDTH:0] diff,
  output logic           borrow
);
  logic [WIDTH+1:0] bw;
  assign bw[0] = 1'b0;
  for (genvar i = 0; i <= WIDTH; i++) begin : g_cell
    assign diff[i]  = a[i] ^ b[i] ^ bw[i];
    assign bw[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
  end
  assign borrow = bw[WIDTH+1];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: start/done multi-cycle unsigned restoring divider, one quotient bit per clock
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_width(WIDTH);
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r, r_sh, d, r_nx;
  logic [WIDTH-1:0] q, dvs, q_nx;
  logic             borrow;
  assign r_sh = {r[WIDTH-1:0], q[WIDTH-1]};
  div_trial_sub #(.WIDTH(WIDTH)) u_sub (
    .a(r_sh),
    .b({1'b0, dvs}),
    .diff(d),
    .borrow(borrow)
  );
  assign r_nx = borrow ? r_sh : d;
  assign q_nx = {q[WIDTH-2:0], ~borrow};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      dvs         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            q   <= dividend;
            dvs <= divisor;
            r   <= '0;
            cnt <= CW'(WIDTH - 1);
            if (divisor == '0) begin
              state       <= ST_DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= ST_CALC;
              busy  <= 1'b1;
            end
          end
        end
        ST_CALC: begin
          r   <= r_nx;
          q   <= q_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            state       <= ST_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_nx;
            remainder   <= r_nx[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule
